// File: rtl/conv_pkg.sv
// Shared constants, coefficient-bank type and identity-kernel builder for the
// 5x5 convolution filter.
// Contents: NTAP / NROW / LAT / CENTRE_TAP / ADDR_W, coeff_arr_t, identity_kernel().
package conv_pkg;

    localparam int unsigned NTAP        = 25;
    localparam int unsigned NROW        = 5;
    localparam int unsigned LAT         = 6;
    localparam int unsigned CENTRE_TAP  = 12;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned COEFF_WIDTH = 9;

    typedef logic [NTAP-1:0][COEFF_WIDTH-1:0] coeff_arr_t;

    // Unity-gain kernel: only the centre tap is set, to 2^shift.
    function automatic coeff_arr_t identity_kernel(input int unsigned shift);
        coeff_arr_t k;
        k = '0;
        k[CENTRE_TAP] = COEFF_WIDTH'(1 << shift);
        return k;
    endfunction

endpackage

// File: rtl/conv5x5_filter_if.sv
// Pixel/status/coefficient bus between the line-delay block and the filter.
// Signals: pa..pe (one column, top to bottom), stat_in, coeff_we/addr/data,
// pix_o, stat_o. master = driver side, slave = filter side.
interface conv5x5_filter_if
    import conv_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned COEFF_W = 9,
    parameter int unsigned STAT_W  = 3
);
    logic [PIX_W-1:0]   pa;
    logic [PIX_W-1:0]   pb;
    logic [PIX_W-1:0]   pc;
    logic [PIX_W-1:0]   pd;
    logic [PIX_W-1:0]   pe;
    logic [STAT_W-1:0]  stat_in;
    logic               coeff_we;
    logic [ADDR_W-1:0]  coeff_addr;
    logic [COEFF_W-1:0] coeff_data;
    logic [PIX_W-1:0]   pix_o;
    logic [STAT_W-1:0]  stat_o;

    modport master (
        output pa, pb, pc, pd, pe, stat_in, coeff_we, coeff_addr, coeff_data,
        input  pix_o, stat_o
    );

    modport slave (
        input  pa, pb, pc, pd, pe, stat_in, coeff_we, coeff_addr, coeff_data,
        output pix_o, stat_o
    );

endinterface

// File: rtl/conv_row_mac.sv
// One window row: five signed-coefficient x unsigned-pixel products, registered,
// then their registered sum (one cycle later).
// Ports: clk, rst (sync, active-high), pix[5], coeff[5], row_sum.
module conv_row_mac
    import conv_pkg::*;
#(
    parameter  int unsigned PIX_W   = 8,
    parameter  int unsigned COEFF_W = 9,
    localparam int unsigned PROD_W  = COEFF_W + PIX_W + 1,
    localparam int unsigned ROW_W   = PROD_W + 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NROW-1:0][PIX_W-1:0]       pix,
    input  logic [NROW-1:0][COEFF_W-1:0]     coeff,
    output logic signed [ROW_W-1:0]          row_sum
);

    logic signed [PROD_W-1:0] prod [NROW];
    logic signed [ROW_W-1:0]  row_next;

    // Sign-extended sum of the registered products.
    always_comb begin
        row_next = '0;
        for (int i = 0; i < int'(NROW); i++) begin
            row_next = row_next + ROW_W'(prod[i]);
        end
    end

    // Pixels are zero-extended by one bit so they multiply as non-negative.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NROW); i++) begin
                prod[i] <= '0;
            end
            row_sum <= '0;
        end else begin
            for (int i = 0; i < int'(NROW); i++) begin
                prod[i] <= PROD_W'($signed(coeff[i])) * PROD_W'($signed({1'b0, pix[i]}));
            end
            row_sum <= row_next;
        end
    end

endmodule

// File: rtl/conv5x5_filter.sv
// 5x5 programmable convolution filter: builds a sliding pixel window from the
// incoming column, applies a signed kernel, rounds/shifts/clamps to PIX_W bits
// and delays the status bits to stay aligned with the filtered pixel.
// Ports: clk, rst (sync, active-high), bus (conv5x5_filter_if.slave).
// Build option: CONV_COEFF_SHADOW_EN adds a shadow coefficient bank that is
// copied to the active bank on each rising edge of stat_in[VS_BIT].
module conv5x5_filter
    import conv_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned COEFF_W = 9,
    parameter int unsigned SHIFT   = 4,
    parameter int unsigned STAT_W  = 3,
    parameter int unsigned VS_BIT  = 1
) (
    input  logic            clk,
    input  logic            rst,
    conv5x5_filter_if.slave bus
);

    localparam int unsigned PROD_W = COEFF_W + PIX_W + 1;
    localparam int unsigned ROW_W  = PROD_W + 3;
    localparam int unsigned SUM_W  = ROW_W + 2;
    localparam int unsigned RES_W  = SUM_W + 1;
    localparam logic signed [RES_W-1:0] RND =
        (SHIFT > 0) ? (RES_W'(1) << (SHIFT - 1)) : '0;
    localparam logic signed [RES_W-1:0] PIX_MAX = RES_W'((1 << PIX_W) - 1);
    localparam coeff_arr_t IDENT = identity_kernel(SHIFT);

    if (VS_BIT >= STAT_W) begin : g_vs_bit_check
        $error("VS_BIT must index a bit of stat_in");
    end

    logic [NROW-1:0][NROW-1:0][PIX_W-1:0] win;      // [row][col], col 0 oldest
    logic [NTAP-1:0][COEFF_W-1:0]         act_bank;
    logic signed [ROW_W-1:0]              row_sum [NROW];
    logic signed [SUM_W-1:0]              total_next;
    logic signed [SUM_W-1:0]              total;
    logic signed [RES_W-1:0]              rounded;
    logic signed [RES_W-1:0]              shifted;
    logic [PIX_W-1:0]                     clamped;
    logic [STAT_W-1:0]                    stat_dly [LAT];
    logic                                 coeff_wr;

    assign coeff_wr = bus.coeff_we && (bus.coeff_addr < ADDR_W'(NTAP));

    // Sliding window: shift left every cycle, new column enters at col 4.
    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
        end else begin
            for (int r = 0; r < int'(NROW); r++) begin
                for (int c = 0; c < int'(NROW) - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            win[0][NROW-1] <= bus.pa;
            win[1][NROW-1] <= bus.pb;
            win[2][NROW-1] <= bus.pc;
            win[3][NROW-1] <= bus.pd;
            win[4][NROW-1] <= bus.pe;
        end
    end

`ifdef CONV_COEFF_SHADOW_EN
    logic [NTAP-1:0][COEFF_W-1:0] shadow_bank;
    logic                         vs_prev;
    logic                         vs_rise;

    assign vs_rise = bus.stat_in[VS_BIT] & ~vs_prev;

    // Writes land in the shadow; the copy uses the pre-write shadow contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NTAP); i++) begin
                act_bank[i]    <= COEFF_W'($signed(IDENT[i]));
                shadow_bank[i] <= COEFF_W'($signed(IDENT[i]));
            end
            vs_prev <= 1'b0;
        end else begin
            vs_prev <= bus.stat_in[VS_BIT];
            if (vs_rise) begin
                act_bank <= shadow_bank;
            end
            if (coeff_wr) begin
                shadow_bank[bus.coeff_addr] <= bus.coeff_data;
            end
        end
    end
`else
    // Writes go straight to the active bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NTAP); i++) begin
                act_bank[i] <= COEFF_W'($signed(IDENT[i]));
            end
        end else if (coeff_wr) begin
            act_bank[bus.coeff_addr] <= bus.coeff_data;
        end
    end
`endif

    for (genvar r = 0; r < int'(NROW); r++) begin : g_row
        conv_row_mac #(
            .PIX_W   (PIX_W),
            .COEFF_W (COEFF_W)
        ) u_mac (
            .clk     (clk),
            .rst     (rst),
            .pix     (win[r]),
            .coeff   (act_bank[r*NROW +: NROW]),
            .row_sum (row_sum[r])
        );
    end

    always_comb begin
        total_next = '0;
        for (int r = 0; r < int'(NROW); r++) begin
            total_next = total_next + SUM_W'(row_sum[r]);
        end
    end

    // Round half up, arithmetic shift, clamp into the pixel range.
    always_comb begin
        rounded = RES_W'(total) + RND;
        shifted = rounded >>> SHIFT;
        if (shifted < 0) begin
            clamped = '0;
        end else if (shifted > PIX_MAX) begin
            clamped = '1;
        end else begin
            clamped = PIX_W'(shifted);
        end
    end

    // Status chain has the same register count as input -> window -> pix_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            total      <= '0;
            bus.pix_o  <= '0;
            bus.stat_o <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                stat_dly[i] <= '0;
            end
        end else begin
            total       <= total_next;
            bus.pix_o   <= clamped;
            stat_dly[0] <= bus.stat_in;
            for (int i = 1; i < int'(LAT); i++) begin
                stat_dly[i] <= stat_dly[i-1];
            end
            bus.stat_o  <= stat_dly[LAT-1];
        end
    end

endmodule

// File: tb/tb_conv5x5_filter.sv
// Directed self-checking bench for conv5x5_filter: identity stream, illegal
// coefficient addresses, write-to-output timing, box kernel, saturation,
// mid-stream reset and status pulse alignment.
module tb_conv5x5_filter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   pix_tab  [64];
    int   stat_tab [64];

    conv5x5_filter_if #(.PIX_W(8), .COEFF_W(9), .STAT_W(3)) bus ();

    conv5x5_filter #(
        .PIX_W   (8),
        .COEFF_W (9),
        .SHIFT   (4),
        .STAT_W  (3),
        .VS_BIT  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input logic [7:0] v);
        bus.pa = v;
        bus.pb = v;
        bus.pc = v;
        bus.pd = v;
        bus.pe = v;
    endtask

    task automatic write_tap(input int addr, input logic [8:0] data);
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = 5'(addr);
        bus.coeff_data = data;
        tick();
        bus.coeff_we   = 1'b0;
    endtask

    task automatic vs_pulse();
        bus.stat_in = 3'b010;
        tick();
        bus.stat_in = 3'b000;
    endtask

    task automatic settle_check(input string tag, input int exp);
        repeat (8) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_%0d", tag, i), 32'(bus.pix_o), 32'(exp));
            tick();
        end
    endtask

    // Identity kernel: pix_o/stat_o are the column inputs 6 edges earlier.
    task automatic stream(input string tag, input int len, input int prev_pix, input int prev_stat);
        for (int i = 0; i < len; i++) begin
            set_pix(8'(pix_tab[i]));
            bus.stat_in = 3'(stat_tab[i]);
            tick();
            check($sformatf("%s_pix_%0d", tag, i), 32'(bus.pix_o),
                  32'((i >= 6) ? pix_tab[i-6] : prev_pix));
            check($sformatf("%s_stat_%0d", tag, i), 32'(bus.stat_o),
                  32'((i >= 6) ? stat_tab[i-6] : prev_stat));
        end
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;

        // Reset state, with non-zero inputs held during reset.
        rst            = 1'b1;
        set_pix(8'd99);
        bus.stat_in    = 3'b111;
        bus.coeff_we   = 1'b0;
        bus.coeff_addr = '0;
        bus.coeff_data = '0;
        tick();
        tick();
        check("rst_pix", 32'(bus.pix_o), 32'd0);
        check("rst_stat", 32'(bus.stat_o), 32'd0);

        // Identity kernel on a counting stream.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pix_tab[i]  = (i * 13 + 5) % 256;
            stat_tab[i] = i % 8;
        end
        stream("ident", 16, 0, 0);

        // Out-of-range addresses must leave the kernel alone.
        set_pix(8'd40);
        bus.stat_in = 3'b000;
        write_tap(25, 9'h100);
        write_tap(31, 9'h0FF);
        settle_check("bad_addr", 40);

        // Tap 12 -> 32 doubles the output, 4 edges after the sampling edge.
        write_tap(12, 9'd32);
        check("wr_t0", 32'(bus.pix_o), 32'd40);
        tick();
        tick();
        tick();
        check("wr_t3", 32'(bus.pix_o), 32'd40);
        tick();
`ifdef CONV_COEFF_SHADOW_EN
        check("wr_t4_shadow", 32'(bus.pix_o), 32'd40);
        vs_pulse();
        tick();
        tick();
        tick();
        check("vs_t3", 32'(bus.pix_o), 32'd40);
        tick();
        check("vs_t4", 32'(bus.pix_o), 32'd80);
`else
        check("wr_t4", 32'(bus.pix_o), 32'd80);
`endif

        // Box kernel, input 16: (400 + 8) >> 4 = 25.
        set_pix(8'd16);
        for (int a = 0; a < 25; a++) write_tap(a, 9'd1);
`ifdef CONV_COEFF_SHADOW_EN
        vs_pulse();
`endif
        settle_check("box", 25);

        // All taps 16, input 255: clamps high.
        set_pix(8'd255);
        for (int a = 0; a < 25; a++) write_tap(a, 9'd16);
`ifdef CONV_COEFF_SHADOW_EN
        vs_pulse();
`endif
        settle_check("sat_hi", 255);

        // Reset mid-stream with a concurrent write that must be dropped.
        bus.stat_in = 3'b101;
        repeat (8) tick();
        check("pre_rst_pix", 32'(bus.pix_o), 32'd255);
        check("pre_rst_stat", 32'(bus.stat_o), 32'd5);
        rst            = 1'b1;
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = 5'd12;
        bus.coeff_data = 9'd5;
        tick();
        check("mid_rst_pix", 32'(bus.pix_o), 32'd0);
        check("mid_rst_stat", 32'(bus.stat_o), 32'd0);
        rst          = 1'b0;
        bus.coeff_we = 1'b0;
        set_pix(8'd77);
        bus.stat_in  = 3'b000;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("post_rst_pix_%0d", k), 32'(bus.pix_o), 32'((k == 7) ? 77 : 0));
            check($sformatf("post_rst_stat_%0d", k), 32'(bus.stat_o), 32'd0);
        end

        // Status pulses of width 2, 4, 6, 8 with a descending pixel ramp.
        n = 0;
        for (int w = 2; w <= 8; w += 2) begin
            for (int j = 0; j < w; j++) begin
                stat_tab[n] = 7;
                n++;
            end
            for (int j = 0; j < ((w == 8) ? 6 : 3); j++) begin
                stat_tab[n] = 0;
                n++;
            end
        end
        for (int i = 0; i < n; i++) pix_tab[i] = 200 - i;
        stream("pulse", n, 77, 0);

        // Tap 12 = -16, input 100: negative sum clamps to 0.
        set_pix(8'd100);
        bus.stat_in = 3'b000;
        write_tap(12, 9'h1F0);
`ifdef CONV_COEFF_SHADOW_EN
        vs_pulse();
`endif
        settle_check("sat_lo", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
